// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32IM pipeline: opcodes, operation encodings,
// the D/E pipeline record and the immediate/ALU decode helpers.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int PC_W   = 12;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_AND    = 5'd2,  ALU_OR    = 5'd3,
        ALU_XOR    = 5'd4,  ALU_SLL   = 5'd5,  ALU_SRL    = 5'd6,  ALU_SRA   = 5'd7,
        ALU_SLT    = 5'd8,  ALU_SLTU  = 5'd9,  ALU_MUL    = 5'd10, ALU_MULH  = 5'd11,
        ALU_MULHSU = 5'd12, ALU_MULHU = 5'd13, ALU_DIV    = 5'd14, ALU_DIVU  = 5'd15,
        ALU_REM    = 5'd16, ALU_REMU  = 5'd17
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0, RES_MEM = 2'd1, RES_PC4 = 2'd2, RES_IMM = 3'd3
    } result_src_t;

    typedef struct packed {
        logic [XLEN-1:0]   dout1;
        logic [XLEN-1:0]   dout2;
        logic [XLEN-1:0]   imm;
        logic [PC_W-1:0]   pc;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_t           alu;
        logic              alu_src;
        result_src_t       res;
        logic              mem_write;
        logic              reg_write;
        logic              branch;
        logic [1:0]        pc_sel;
        logic [2:0]        funct3;
    } de_t;

    function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] ins, input imm_src_t src);
        case (src)
            IMM_I:   imm_extend = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_extend = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_extend = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm_extend = {ins[31:12], 12'h000};
            IMM_J:   imm_extend = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_extend = {XLEN{1'b0}};
        endcase
    endfunction

    // alt selects SUB/SRA; mext selects the multiply/divide group
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt, input logic mext);
        if (mext) begin
            case (f3)
                3'b000:  alu_decode = ALU_MUL;
                3'b001:  alu_decode = ALU_MULH;
                3'b010:  alu_decode = ALU_MULHSU;
                3'b011:  alu_decode = ALU_MULHU;
                3'b100:  alu_decode = ALU_DIV;
                3'b101:  alu_decode = ALU_DIVU;
                3'b110:  alu_decode = ALU_REM;
                default: alu_decode = ALU_REMU;
            endcase
        end else begin
            case (f3)
                3'b000:  alu_decode = alt ? ALU_SUB : ALU_ADD;
                3'b001:  alu_decode = ALU_SLL;
                3'b010:  alu_decode = ALU_SLT;
                3'b011:  alu_decode = ALU_SLTU;
                3'b100:  alu_decode = ALU_XOR;
                3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_decode = ALU_OR;
                default: alu_decode = ALU_AND;
            endcase
        end
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with write-through
// bypass, one write port, x0 hard-wired to zero, asynchronous clear.
module reg_file
    import cpu_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs_q [1:(2**AW)-1];

    // Register array with asynchronous clear; x0 has no storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 2**AW; i++) regs_q[i] <= '0;
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Read ports, forwarding the value being written this cycle
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 == '0)                  rdata1 = '0;
        else if (we && (waddr == raddr1))  rdata1 = wdata;
        else                               rdata1 = regs_q[raddr1];
        if (raddr2 == '0)                  rdata2 = '0;
        else if (we && (waddr == raddr2))  rdata2 = wdata;
        else                               rdata2 = regs_q[raddr2];
    end

endmodule

// File: rtl/decode_stage.sv
// RV32IM decode stage: control decode, immediate extension, load-use hazard
// detection, register file and the D/E pipeline register.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROM_WIDTH  = 12,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instrD,
    input  logic [ROM_WIDTH-1:0]  pcD,
    input  logic                  flushE,
    input  logic                  regWriteW,
    input  logic [REG_ADDR-1:0]   rdW,
    input  logic [DATA_WIDTH-1:0] resultW,
    output logic                  stallF,
    output logic                  stallD,
    output logic [DATA_WIDTH-1:0] dout1E,
    output logic [DATA_WIDTH-1:0] dout2E,
    output logic [DATA_WIDTH-1:0] immExtE,
    output logic [ROM_WIDTH-1:0]  pcE,
    output logic [REG_ADDR-1:0]   rs1E,
    output logic [REG_ADDR-1:0]   rs2E,
    output logic [REG_ADDR-1:0]   rdE,
    output logic [4:0]            aluCtrlE,
    output logic                  aluSrcE,
    output logic [1:0]            resultSrcE,
    output logic                  memWriteE,
    output logic                  regWriteE,
    output logic                  branchE,
    output logic [1:0]            pcSelModeE,
    output logic [2:0]            funct3E
);

    logic [6:0]            opcode_s;
    logic [REG_ADDR-1:0]   rs1_s, rs2_s, rd_s;
    logic [DATA_WIDTH-1:0] rdata1_s, rdata2_s;
    logic                  reg_write_s, mem_write_s, branch_s, alu_src_s;
    logic                  use_rs1_s, use_rs2_s, hz_s;
    logic [1:0]            pc_sel_s;
    result_src_t           result_src_s;
    imm_src_t              imm_src_s;
    alu_op_t               alu_op_s;
    de_t                   de_d, de_q;

    assign opcode_s = instrD[6:0];
    assign rd_s     = instrD[11:7];
    assign rs1_s    = instrD[19:15];
    assign rs2_s    = instrD[24:20];

    reg_file #(.DW(DATA_WIDTH), .AW(REG_ADDR)) u_reg_file (
        .clk    (clk),
        .rst    (rst),
        .we     (regWriteW),
        .waddr  (rdW),
        .wdata  (resultW),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .rdata1 (rdata1_s),
        .rdata2 (rdata2_s)
    );

    // Control decode; anything unrecognised (including the all-zero bubble) enables nothing
    always_comb begin
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        branch_s     = 1'b0;
        alu_src_s    = 1'b0;
        use_rs1_s    = 1'b0;
        use_rs2_s    = 1'b0;
        pc_sel_s     = 2'd0;
        result_src_s = RES_ALU;
        imm_src_s    = IMM_I;
        alu_op_s     = ALU_ADD;
        case (opcode_s)
            OPC_OP: begin
                reg_write_s = 1'b1;
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                alu_op_s    = alu_decode(instrD[14:12], instrD[30], instrD[31:25] == FUNCT7_MEXT);
            end
            OPC_OP_IMM: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                use_rs1_s   = 1'b1;
                alu_op_s    = alu_decode(instrD[14:12], (instrD[14:12] == 3'b101) && instrD[30], 1'b0);
            end
            OPC_LOAD: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                use_rs1_s    = 1'b1;
                result_src_s = RES_MEM;
            end
            OPC_STORE: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                imm_src_s   = IMM_S;
            end
            OPC_BRANCH: begin
                branch_s  = 1'b1;
                use_rs1_s = 1'b1;
                use_rs2_s = 1'b1;
                imm_src_s = IMM_B;
                alu_op_s  = ALU_SUB;
                pc_sel_s  = 2'd1;
            end
            OPC_JAL: begin
                reg_write_s  = 1'b1;
                result_src_s = RES_PC4;
                imm_src_s    = IMM_J;
                pc_sel_s     = 2'd1;
            end
            OPC_JALR: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                use_rs1_s    = 1'b1;
                result_src_s = RES_PC4;
                pc_sel_s     = 2'd2;
            end
            OPC_LUI: begin
                reg_write_s  = 1'b1;
                result_src_s = RES_IMM;
                imm_src_s    = IMM_U;
            end
            OPC_AUIPC: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_src_s   = IMM_U;
            end
            default: begin
                reg_write_s = 1'b0;
            end
        endcase
    end

    // A load in E whose destination is a source used by D costs one bubble
    assign hz_s = (de_q.res == RES_MEM) && de_q.reg_write && (de_q.rd != '0) &&
                  ((use_rs1_s && (de_q.rd == rs1_s)) || (use_rs2_s && (de_q.rd == rs2_s)));
    assign stallF = hz_s;
    assign stallD = hz_s;

    // Next D/E contents: a bubble on flush or hazard, otherwise the decoded instruction
    always_comb begin
        de_d = '0;
        if (flushE || hz_s) begin
            de_d = '0;
        end else begin
            de_d.dout1     = rdata1_s;
            de_d.dout2     = rdata2_s;
            de_d.imm       = imm_extend(instrD, imm_src_s);
            de_d.pc        = pcD;
            de_d.rs1       = rs1_s;
            de_d.rs2       = rs2_s;
            de_d.rd        = rd_s;
            de_d.alu       = alu_op_s;
            de_d.alu_src   = alu_src_s;
            de_d.res       = result_src_s;
            de_d.mem_write = mem_write_s;
            de_d.reg_write = reg_write_s;
            de_d.branch    = branch_s;
            de_d.pc_sel    = pc_sel_s;
            de_d.funct3    = instrD[14:12];
        end
    end

    // D/E pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) de_q <= '0;
        else      de_q <= de_d;
    end

    assign dout1E     = de_q.dout1;
    assign dout2E     = de_q.dout2;
    assign immExtE    = de_q.imm;
    assign pcE        = de_q.pc;
    assign rs1E       = de_q.rs1;
    assign rs2E       = de_q.rs2;
    assign rdE        = de_q.rd;
    assign aluCtrlE   = de_q.alu;
    assign aluSrcE    = de_q.alu_src;
    assign resultSrcE = de_q.res;
    assign memWriteE  = de_q.mem_write;
    assign regWriteE  = de_q.reg_write;
    assign branchE    = de_q.branch;
    assign pcSelModeE = de_q.pc_sel;
    assign funct3E    = de_q.funct3;

endmodule
